// File: rtl/aes_round_key_store.sv
// Round-key buffer behind the AES-128 key expansion stage. It captures NR+1 round keys after a
// key load and serves them through a one-cycle read port in forward or reverse order.
module aes_round_key_store #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [31:0]  wi_0,
  input  logic [31:0]  wi_1,
  input  logic [31:0]  wi_2,
  input  logic [31:0]  wi_3,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  input  logic         rd_dec,
  output logic         key_ready,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StReady   = 2'd2;

  localparam logic [3:0] LastIdx = 4'(NR);

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         wr_en;
  logic [127:0] slot_q [NR+1];

  logic         rd_acc;
  logic         rd_oob;
  logic [3:0]   rd_idx;
  logic         rd_valid_q;
  logic [127:0] rd_key_q;
  logic         rd_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (kld) begin
      // Load restarts capture from any state; round key 0 arrives next cycle.
      state_d = StCapture;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        StCapture: begin
          wr_en = 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StReady;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_ready = (state_q == StReady);

  assign rd_acc = rd_en & key_ready & ~kld;
  assign rd_oob = (rd_round > LastIdx);
  // Out-of-range requests are steered to slot 0 so the array is never indexed past its end.
  assign rd_idx = rd_oob ? 4'd0 : (rd_dec ? (LastIdx - rd_round) : rd_round);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_key_q <= rd_oob ? '0 : slot_q[rd_idx];
        rd_err_q <= rd_oob;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      slot_q[cnt_q] <= {wi_0, wi_1, wi_2, wi_3};
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_key   = rd_key_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Scoreboard bench for aes_round_key_store: the driver queues expected read responses, and a
// negedge monitor pops and compares them whenever rd_valid is seen.
module tb_aes_round_key_store;

  logic         clk = 1'b0;
  logic         rst, kld, rd_en, rd_dec;
  logic [31:0]  wi_0, wi_1, wi_2, wi_3;
  logic [3:0]   rd_round;
  logic         key_ready, rd_valid, rd_err;
  logic [127:0] rd_key;

  aes_round_key_store #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .kld       (kld),
    .wi_0      (wi_0),
    .wi_1      (wi_1),
    .wi_2      (wi_2),
    .wi_3      (wi_3),
    .rd_en     (rd_en),
    .rd_round  (rd_round),
    .rd_dec    (rd_dec),
    .key_ready (key_ready),
    .rd_valid  (rd_valid),
    .rd_key    (rd_key),
    .rd_err    (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [127:0] k1 [11];
  logic [127:0] k2 [11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [127:0] tbl(input int sel, input int i);
    return (sel == 1) ? k1[i] : k2[i];
  endfunction

  // Monitor: every rd_valid must match the oldest queued request, one cycle after issue.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got rd_valid=1 key=%h expected no response", rd_key);
      end else begin
        e = sb.pop_front();
        check("rd_latency", 128'(cyc), 128'(e.cyc + 1));
        check("rd_key", rd_key, e.key);
        check("rd_err", 128'(rd_err), 128'(e.err));
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_valid: got rd_valid=0 expected key %h", e.key);
    end
  end

  // Drives a request on the current cycle; queues a response only if it should be accepted.
  task automatic req(input int r, input bit d, input bit accept, input int sel);
    exp_t e;
    kld      = 1'b0;
    rd_en    = 1'b1;
    rd_round = 4'(r);
    rd_dec   = d;
    if (accept) begin
      e.err = (r > 10);
      e.key = (r > 10) ? 128'h0 : tbl(sel, d ? 10 - r : r);
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  // kld for one cycle, then n capture cycles; rd_en stays high throughout and must be dropped.
  task automatic load(input int sel, input int n, input bit inv);
    @(negedge clk);
    kld      = 1'b1;
    rd_en    = 1'b1;
    rd_round = 4'd0;
    rd_dec   = 1'b0;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      check("capture_not_ready", 128'(key_ready), 128'h0);
      kld = 1'b0;
      {wi_0, wi_1, wi_2, wi_3} = inv ? ~tbl(sel, r) : tbl(sel, r);
    end
  endtask

  initial begin
    k1 = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
           128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
           128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
           128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
           128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
           128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    k2 = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
           128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
           128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
           128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
           128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
           128'h13111d7fe3944a17f307a78b4d2b30c5};
    rst = 1'b1; kld = 1'b0; rd_en = 1'b0; rd_dec = 1'b0; rd_round = 4'd0;
    {wi_0, wi_1, wi_2, wi_3} = '0;
    repeat (2) @(negedge clk);
    check("reset_key_ready", 128'(key_ready), 128'h0);
    check("reset_rd_valid", 128'(rd_valid), 128'h0);
    check("reset_rd_key", rd_key, 128'h0);
    check("reset_rd_err", 128'(rd_err), 128'h0);
    rst = 1'b0;
    req(0, 0, 0, 1);                     // IDLE: dropped

    // First key; round 10 is read in the very cycle key_ready rises.
    load(1, 11, 0);
    @(negedge clk); check("ready_rise", 128'(key_ready), 128'h1); req(10, 0, 1, 1);
    @(negedge clk); req(0, 0, 1, 1);
    @(negedge clk); req(1, 0, 1, 1);
    @(negedge clk); rd_en = 1'b0;
    @(negedge clk); check("hold_key", rd_key, k1[1]);
    check("hold_valid_low", 128'(rd_valid), 128'h0);

    // Reverse order, 11 back-to-back requests.
    for (int r = 0; r <= 10; r++) begin
      @(negedge clk); req(r, 1, 1, 1);
    end
    @(negedge clk); req(12, 0, 1, 1);    // out of range
    @(negedge clk); req(15, 1, 1, 1);
    @(negedge clk); req(5, 0, 1, 1);
    @(negedge clk); rd_en = 1'b0;

    // Reload from READY (kld beats rd_en), abort at capture cycle 5, reload again.
    load(2, 5, 1);
    load(2, 11, 0);
    @(negedge clk); check("reload_ready", 128'(key_ready), 128'h1); req(10, 0, 1, 2);
    @(negedge clk); req(0, 0, 1, 2);
    @(negedge clk); req(10, 1, 1, 2);
    @(negedge clk); req(3, 1, 1, 2);
    @(negedge clk); rd_en = 1'b0;

    // Reset mid-capture with rd_en held high.
    load(1, 4, 0);
    @(negedge clk); rst = 1'b1; req(0, 0, 0, 1);
    @(negedge clk);
    check("midrst_key_ready", 128'(key_ready), 128'h0);
    check("midrst_rd_valid", 128'(rd_valid), 128'h0);
    check("midrst_rd_key", rd_key, 128'h0);
    check("midrst_rd_err", 128'(rd_err), 128'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); req(10, 0, 0, 1);
    end
    load(1, 11, 0);
    @(negedge clk); check("post_rst_ready", 128'(key_ready), 128'h1); req(10, 1, 1, 1);
    @(negedge clk); req(10, 0, 1, 1);
    @(negedge clk); rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_round_key_store.md
# aes_round_key_store

Round-key buffer that sits directly downstream of the AES-128 key expansion stage. It captures the 11 round keys that stage produces on consecutive cycles after a key load, holds them in a local register file, and serves any round key to the cipher datapath through a one-cycle-latency read port. Keys can be read in encryption (forward) or decryption (reverse) order, so a single expansion pass serves both directions.

## Interface
- NR, default 10: number of cipher rounds; NR+1 round keys are stored. Only 10 (AES-128) is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- kld  input  1  key-load strobe. Driven by the same signal as the expansion stage's key-enable, in the same cycle.
- wi_0  input  32  round-key word 0 (MSW) from the expansion stage.
- wi_1  input  32  round-key word 1.
- wi_2  input  32  round-key word 2.
- wi_3  input  32  round-key word 3 (LSW).
- rd_en  input  1  read request.
- rd_round  input  4  requested round index, 0..NR.
- rd_dec  input  1  1 = decryption order: the slot read is NR-rd_round.
- key_ready  output  1  all NR+1 keys captured and valid.
- rd_valid  output  1  rd_key and rd_err are valid this cycle.
- rd_key  output  128  round key, {w0,w1,w2,w3}.
- rd_err  output  1  the accepted request had rd_round > NR.

## Operation
- The register file holds slot[0..NR], 128 bits each. Slots are not cleared by reset.
- FSM states:
  - IDLE: no key loaded; entered on reset.
  - CAPTURE: receiving keys; a counter cnt runs 0..NR.
  - READY: all keys stored.
- FSM transitions:
  - kld=1 in any state → CAPTURE, cnt=0, key_ready=0.
  - CAPTURE with kld=0: write {wi_0,wi_1,wi_2,wi_3} into slot[cnt], then cnt+1. When cnt=NR is written → READY.
  - READY holds until kld or rst.
- Capture alignment:
  - The expansion stage presents round key 0 (the cipher key) the cycle after kld, and round key r r+1 cycles after kld.
  - The capture writes therefore start the cycle after kld.
- Read port:
  - A request is accepted only when rd_en=1, key_ready=1 and kld=0 in the same cycle.
  - Requests in any other cycle are dropped and produce no rd_valid.
  - Slot index is rd_dec ? NR-rd_round : rd_round.
  - If rd_round > NR: rd_err=1 and rd_key=0.
- Back-to-back requests are accepted every cycle. There is no backpressure.
- kld during CAPTURE restarts the capture from slot 0. Partially written slots are overwritten.
- kld in READY drops key_ready the next cycle. Old slot contents stay readable only internally; no read is accepted until the new capture completes.

## Timing
- Reset values: key_ready=0, rd_valid=0, rd_key=0, rd_err=0; FSM in IDLE; cnt=0.
- Define E0 as the rising edge where kld=1 is sampled:
  - Slot r is written at edge E(r+1).
  - key_ready rises after E11 and is visible in the cycle following E11.
  - Total load-to-ready latency is 11 cycles.
- Read latency is 1 cycle. A request accepted at edge Ek gives rd_valid=1 with data in the cycle after Ek.
- rd_valid is a single-cycle pulse per accepted request. When no request is accepted, rd_valid returns to 0; rd_key and rd_err hold their last values.
- A read of slot NR in the cycle key_ready first goes high returns the newly written key. There is no write/read hazard, because writing has finished by then.
- rst has priority over kld; kld has priority over rd_en.

## Test plan
- Load key 2b7e151628aed2a6abf7158809cf4f3c with kld for 1 cycle, expansion stage attached.
  - key_ready must be 0 for cycles 1..10 after E0 and 1 at cycle 11.
- Forward reads of rounds 0, 1 and 10:
  - Returns 2b7e151628aed2a6abf7158809cf4f3c, a0fafe1788542cb123a339392a6c7605 and d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Each with rd_valid 1 cycle after the request.
- rd_dec=1 sequence:
  - rd_round=0 returns d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=10 returns the cipher key.
  - 11 back-to-back requests give 11 consecutive rd_valid pulses in reverse key order.
- rd_en while key_ready=0 (during capture) gives no rd_valid.
- rd_round=12 in READY gives rd_valid=1, rd_err=1, rd_key=0.
- kld re-asserted at cycle 5 of capture with key 000102030405060708090a0b0c0d0e0f:
  - key_ready stays 0 until 11 cycles after the second kld.
  - Round 10 then reads 13111d7fe3944a17f307a78b4d2b30c5.
- rst asserted mid-capture: all outputs return to 0 the next cycle and the FSM is in IDLE; rd_en is ignored until a new kld completes.
